// File: rtl/keypad_button_led.sv
// Keypad scanner, button-driven area selector and area LED bar for the dot-matrix game.
// Keypad results land in dot only at sweep ends; buttons are synchronized and edge-detected.
module keypad_button_led #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        finish,
    input  logic        switch,
    input  logic [3:0]  keycol,
    input  logic [3:0]  button,
    output logic [3:0]  keyrow,
    output logic [15:0] dot,
    output logic [2:0]  area,
    output logic [7:0]  led
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    cand_q, cand_d;
    logic          cand_vld_q, cand_vld_d;
    logic [15:0]   dot_q, dot_d;
    logic [3:0]    sync1_q, sync2_q, prev_q;
    logic [2:0]    area_q, area_d;
    logic [7:0]    led_q, led_d;

    logic       row_last, col_hit, enable;
    logic [1:0] col_idx;
    logic [3:0] key_idx;
    logic [3:0] rise;

    assign enable = switch && !finish;
    assign rise   = sync2_q & ~prev_q;

    always_comb begin
        row_last = (cnt_q == CNT_MAX);
        col_hit  = (keycol != 4'hF);
        col_idx  = 2'd0;
        // Scan high to low so the lowest closed column wins.
        for (int c = 3; c >= 0; c--) begin
            if (!keycol[c]) col_idx = 2'(c);
        end
        key_idx = {row_q, col_idx};

        cnt_d      = row_last ? '0 : cnt_q + CW'(1);
        row_d      = row_last ? row_q + 2'd1 : row_q;
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        dot_d      = dot_q;

        if (row_last && col_hit && (!cand_vld_q || key_idx < cand_q)) begin
            cand_d     = key_idx;
            cand_vld_d = 1'b1;
        end
        if (row_last && row_q == 2'd3) begin
            dot_d      = (enable && cand_vld_d) ? (16'd1 << cand_d) : 16'd0;
            cand_d     = 4'd0;
            cand_vld_d = 1'b0;
        end
    end

    always_comb begin
        area_d = area_q;
        if (enable) begin
            if (rise[2])      area_d = 3'd0;
            else if (rise[0]) area_d = area_q + 3'd1;
            else if (rise[1]) area_d = area_q - 3'd1;
            else if (rise[3]) area_d = 3'd7;
        end

        if (finish)       led_d = 8'hFF;
        else if (!switch) led_d = 8'h00;
        else              led_d = 8'd1 << area_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            row_q      <= 2'd0;
            cand_q     <= 4'd0;
            cand_vld_q <= 1'b0;
            dot_q      <= 16'd0;
            sync1_q    <= 4'd0;
            sync2_q    <= 4'd0;
            prev_q     <= 4'd0;
            area_q     <= 3'd0;
            led_q      <= 8'd0;
        end else begin
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
            dot_q      <= dot_d;
            sync1_q    <= button;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            area_q     <= area_d;
            led_q      <= led_d;
        end
    end

    assign keyrow = ~(4'b0001 << row_q);
    assign dot    = dot_q;
    assign area   = area_q;
    assign led    = led_q;
endmodule

// File: tb/tb_keypad_button_led.sv
// Scoreboard bench for keypad_button_led with a 4-row keypad matrix model, SCAN_DIV=4.
module tb_keypad_button_led;
    logic        clock, reset, finish, switch;
    logic [3:0]  keycol, button, keyrow;
    logic [15:0] dot;
    logic [2:0]  area;
    logic [7:0]  led;
    logic [15:0] pressed;

    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    logic [2:0]  area_m;
    int checks, errors;

    keypad_button_led #(.SCAN_DIV(4)) dut (
        .clock(clock), .reset(reset), .finish(finish), .switch(switch),
        .keycol(keycol), .button(button), .keyrow(keyrow), .dot(dot),
        .area(area), .led(led)
    );

    always #5 clock = ~clock;

    // Keypad matrix: a closed key pulls its column low while its row is driven.
    always_comb begin
        keycol = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!keyrow[r])
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c]) keycol[c] = 1'b0;
    end

    function automatic logic [2:0] next_area(input logic [2:0] a, input logic [3:0] b);
        if (b[2]) return 3'd0;
        if (b[0]) return 3'(a + 3'd1);
        if (b[1]) return 3'(a - 3'd1);
        if (b[3]) return 3'd7;
        return a;
    endfunction

    function automatic logic [7:0] led_model(input logic [2:0] a);
        if (finish) return 8'hFF;
        if (!switch) return 8'h00;
        return 8'd1 << a;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_sweep_end();
        logic [3:0] prev;
        bit seen;
        seen = 0;
        prev = keyrow;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (prev == 4'b0111 && keyrow == 4'b1110) begin
                seen = 1;
                break;
            end
            prev = keyrow;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL sweep_timeout: keyrow=%b never wrapped 0111->1110", keyrow);
        end
    endtask

    task automatic check_dot(input string nm);
        exp_v = exp_q.pop_front();
        checks++;
        if (dot !== exp_v) begin
            errors++;
            $display("FAIL %s: dot=%h expected %h", nm, dot, exp_v);
        end
    endtask

    task automatic press_btn(input logic [3:0] b, input string nm);
        logic [2:0] old;
        old = area_m;
        if (switch && !finish) area_m = next_area(area_m, b);
        exp_q.push_back({13'd0, area_m});
        button = b;
        tick(2);
        checks++;
        if (area !== old) begin
            errors++;
            $display("FAIL %s_early: area=%0d expected %0d", nm, area, old);
        end
        tick(1);
        exp_v = exp_q.pop_front();
        checks++;
        if (area !== exp_v[2:0]) begin
            errors++;
            $display("FAIL %s: area=%0d expected %0d", nm, area, exp_v[2:0]);
        end
        tick(1);
        checks++;
        if (led !== led_model(area_m)) begin
            errors++;
            $display("FAIL %s_led: led=%h expected %h", nm, led, led_model(area_m));
        end
        button = 4'd0;
        tick(3);
    endtask

    task automatic test_reset();
        reset = 1;
        tick(3);
        exp_q.push_back(16'h000E); exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        exp_v = exp_q.pop_front(); checks++;
        if (keyrow !== exp_v[3:0]) begin errors++; $display("FAIL reset_keyrow: %b expected %b", keyrow, exp_v[3:0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (dot !== exp_v) begin errors++; $display("FAIL reset_dot: %h expected %h", dot, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (area !== exp_v[2:0]) begin errors++; $display("FAIL reset_area: %0d expected %0d", area, exp_v[2:0]); end
        exp_v = exp_q.pop_front(); checks++;
        if (led !== exp_v[7:0]) begin errors++; $display("FAIL reset_led: %h expected %h", led, exp_v[7:0]); end
        reset = 0;
        area_m = 3'd0;
        for (int j = 0; j < 16; j++) exp_q.push_back({12'd0, ~(4'b0001 << (j / 4))});
        for (int j = 0; j < 16; j++) begin
            if (j > 0) tick(1);
            exp_v = exp_q.pop_front();
            checks++;
            if (keyrow !== exp_v[3:0]) begin
                errors++;
                $display("FAIL row_step[%0d]: keyrow=%b expected %b", j, keyrow, exp_v[3:0]);
            end
        end
    endtask

    task automatic test_keypad();
        logic [15:0] keys [6];
        logic [15:0] want [6];
        keys[0] = 16'h0400; want[0] = 16'h0400;
        keys[1] = 16'h0000; want[1] = 16'h0000;
        keys[2] = 16'h0220; want[2] = 16'h0020;
        keys[3] = 16'h0050; want[3] = 16'h0010;
        keys[4] = 16'h8000; want[4] = 16'h8000;
        keys[5] = 16'h8001; want[5] = 16'h0001;
        switch = 1;
        wait_sweep_end();
        for (int k = 0; k < 6; k++) begin
            pressed = keys[k];
            exp_q.push_back(want[k]);
            wait_sweep_end();
            check_dot($sformatf("keypad[%0d]", k));
        end
        pressed = 0;
        wait_sweep_end();
    endtask

    task automatic test_buttons();
        for (int i = 0; i < 3; i++) press_btn(4'b0001, "btn0_inc");
        for (int i = 0; i < 4; i++) press_btn(4'b0010, "btn1_dec");
        press_btn(4'b0100, "btn2_zero");
        press_btn(4'b1000, "btn3_seven");
    endtask

    task automatic test_simultaneous();
        press_btn(4'b0010, "to6");
        press_btn(4'b0010, "to5");
        press_btn(4'b0101, "b0_b2_same_edge");
        press_btn(4'b1011, "b0_b1_b3_same_edge");
        area_m = next_area(area_m, 4'b0001);
        exp_q.push_back({13'd0, area_m});
        button = 4'b0001;
        tick(20);
        exp_v = exp_q.pop_front();
        checks++;
        if (area !== exp_v[2:0]) begin
            errors++;
            $display("FAIL hold_one_inc: area=%0d expected %0d", area, exp_v[2:0]);
        end
        button = 0;
        tick(3);
    endtask

    task automatic test_gating();
        switch = 0;
        tick(1);
        checks++;
        if (led !== 8'h00) begin errors++; $display("FAIL idle_led: led=%h expected 00", led); end
        press_btn(4'b0001, "idle_btn");
        pressed = 16'h0008;
        wait_sweep_end();
        exp_q.push_back(16'h0000);
        wait_sweep_end();
        check_dot("idle_dot");
        switch = 1;
        wait_sweep_end();
        exp_q.push_back(16'h0008);
        wait_sweep_end();
        check_dot("enabled_dot");
        finish = 1;
        tick(1);
        checks++;
        if (led !== 8'hFF) begin errors++; $display("FAIL finish_led: led=%h expected ff", led); end
        press_btn(4'b1000, "finish_btn");
        exp_q.push_back(16'h0000);
        wait_sweep_end();
        check_dot("finish_dot");
        finish = 0;
        pressed = 0;
        tick(1);
    endtask

    task automatic test_reset_mid();
        bit seen;
        pressed = 16'h0020;
        wait_sweep_end();
        exp_q.push_back(16'h0020);
        wait_sweep_end();
        check_dot("pre_reset_dot");
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (keyrow == 4'b1011) begin seen = 1; break; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL row2_timeout: keyrow=%b", keyrow);
        end
        reset = 1;
        tick(1);
        exp_q.push_back(16'h0000);
        check_dot("mid_reset_dot");
        checks++;
        if (keyrow !== 4'b1110) begin errors++; $display("FAIL mid_reset_keyrow: %b expected 1110", keyrow); end
        area_m = 0;
        pressed = 0;
        reset = 0;
        exp_q.push_back(16'h0000);
        wait_sweep_end();
        check_dot("no_stale_dot");
        press_btn(4'b0001, "post_reset_btn");
    endtask

    initial begin
        clock = 0; reset = 1; finish = 0; switch = 0;
        button = 0; pressed = 0; area_m = 0;
        checks = 0; errors = 0;
        test_reset();
        test_keypad();
        test_buttons();
        test_simultaneous();
        test_gating();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
